// File: rtl/pipe_stall_ctrl_if.sv
// Sequencing bundle between the pipeline datapath (master) and the stall controller (slave).
interface pipe_stall_ctrl_if #(
  parameter int unsigned CNT_W  = 5,
  parameter int unsigned PERF_W = 32
);
  logic              stallreq_id;
  logic              ex_mc_start;
  logic [CNT_W-1:0]  ex_mc_cycles;
  logic              flush;
  logic [5:0]        stall;
  logic              mc_busy;
  logic              mc_done;
  logic [PERF_W-1:0] stall_cycles;

  modport master (
    output stallreq_id, ex_mc_start, ex_mc_cycles, flush,
    input  stall, mc_busy, mc_done, stall_cycles
  );

  modport slave (
    input  stallreq_id, ex_mc_start, ex_mc_cycles, flush,
    output stall, mc_busy, mc_done, stall_cycles
  );
endinterface

// File: rtl/pipe_stall_ctrl.sv
// Stall vector generation for the 5-stage core, multi-cycle EX timer, flush abort
// and a saturating stall-cycle counter.
module pipe_stall_ctrl #(
  parameter int unsigned CNT_W  = 5,
  parameter int unsigned PERF_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  pipe_stall_ctrl_if.slave bus
);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  localparam logic [5:0] STALL_EX = 6'b001111;
  localparam logic [5:0] STALL_ID = 6'b000111;

  state_t            state;
  logic [CNT_W-1:0]  cnt;
  logic              mc_busy;
  logic              mc_done;
  logic [PERF_W-1:0] stall_cycles;
  logic [5:0]        stall;
  logic              mc_long;

  // Ops of latency 0 or 1 finish without ever holding the front of the pipe.
  assign mc_long = (bus.ex_mc_cycles >= CNT_W'(2));

  // Stall vector, highest-priority source first.
  always_comb begin
    stall = 6'b000000;
    if (bus.flush) begin
      stall = 6'b000000;
    end else if (state == BUSY) begin
      stall = STALL_EX;
    end else if ((state == IDLE) && bus.ex_mc_start && mc_long) begin
      stall = STALL_EX;
    end else if (bus.stallreq_id) begin
      stall = STALL_ID;
    end
  end

  // Timer FSM with registered status flags and the performance counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      cnt          <= '0;
      mc_busy      <= 1'b0;
      mc_done      <= 1'b0;
      stall_cycles <= '0;
    end else begin
      if (stall[0] && (stall_cycles != {PERF_W{1'b1}})) begin
        stall_cycles <= stall_cycles + PERF_W'(1);
      end

      if (bus.flush) begin
        state   <= IDLE;
        cnt     <= '0;
        mc_busy <= 1'b0;
        mc_done <= 1'b0;
      end else begin
        case (state)
          IDLE: begin
            if (bus.ex_mc_start) begin
              if (!mc_long) begin
                state   <= DONE;
                mc_done <= 1'b1;
              end else begin
                state   <= BUSY;
                cnt     <= bus.ex_mc_cycles - CNT_W'(2);
                mc_busy <= 1'b1;
              end
            end
          end
          BUSY: begin
            if (cnt != '0) begin
              cnt <= cnt - CNT_W'(1);
            end else begin
              state   <= DONE;
              mc_busy <= 1'b0;
              mc_done <= 1'b1;
            end
          end
          DONE: begin
            // The op leaves EX at this edge; a still-high start is the same op.
            state   <= IDLE;
            mc_done <= 1'b0;
          end
          default: begin
            state   <= IDLE;
            cnt     <= '0;
            mc_busy <= 1'b0;
            mc_done <= 1'b0;
          end
        endcase
      end
    end
  end

  assign bus.stall        = stall;
  assign bus.mc_busy      = mc_busy;
  assign bus.mc_done      = mc_done;
  assign bus.stall_cycles = stall_cycles;

endmodule

// File: tb/tb_pipe_stall_ctrl.sv
// Directed bench for pipe_stall_ctrl: reset, ID stalls, multi-cycle timing, flush and
// counter saturation (on a narrow-counter instance).
module tb_pipe_stall_ctrl;

  logic clk;
  logic rst;

  pipe_stall_ctrl_if #(.CNT_W(5), .PERF_W(32)) bus ();
  pipe_stall_ctrl_if #(.CNT_W(5), .PERF_W(3))  bus2 ();

  pipe_stall_ctrl #(.CNT_W(5), .PERF_W(32)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  pipe_stall_ctrl #(.CNT_W(5), .PERF_W(3)) dut_sat (
    .clk (clk),
    .rst (rst),
    .bus (bus2)
  );

  int          vectors;
  int          miscompares;
  logic [31:0] exp_perf;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    bus.stallreq_id = 1'b0; bus.ex_mc_start = 1'b0; bus.ex_mc_cycles = '0; bus.flush = 1'b0;
    bus2.stallreq_id = 1'b0; bus2.ex_mc_start = 1'b0; bus2.ex_mc_cycles = '0; bus2.flush = 1'b0;
    tick;
    tick;
    rst = 1'b0;
    #1;
    vectors++;
    if ({bus.stall, bus.mc_busy, bus.mc_done} !== 8'h00) begin
      miscompares++;
      $display("FAIL reset_outputs got=%h want=%h", {bus.stall, bus.mc_busy, bus.mc_done}, 8'h00);
    end
    vectors++;
    if (bus.stall_cycles !== 32'd0) begin
      miscompares++;
      $display("FAIL reset_perf got=%0d want=0", bus.stall_cycles);
    end
    exp_perf = 32'd0;
  endtask

  task automatic test_stallreq;
    bus.stallreq_id = 1'b1;
    #1;
    vectors++;
    if ({bus.stall, bus.mc_busy, bus.mc_done} !== 8'h1C) begin
      miscompares++;
      $display("FAIL stallreq_on got=%h want=%h", {bus.stall, bus.mc_busy, bus.mc_done}, 8'h1C);
    end
    tick;
    exp_perf = exp_perf + 1;
    bus.stallreq_id = 1'b0;
    #1;
    vectors++;
    if ({bus.stall, bus.mc_busy, bus.mc_done} !== 8'h00) begin
      miscompares++;
      $display("FAIL stallreq_off got=%h want=%h", {bus.stall, bus.mc_busy, bus.mc_done}, 8'h00);
    end
    vectors++;
    if (bus.stall_cycles !== exp_perf) begin
      miscompares++;
      $display("FAIL stallreq_perf got=%0d want=%0d", bus.stall_cycles, exp_perf);
    end
  endtask

  // {stall, mc_busy, mc_done}: IDLE-accept, 3x BUSY, DONE, then idle.
  task automatic test_mc4;
    logic [7:0] exp_v [7] = '{8'h3C, 8'h3E, 8'h3E, 8'h3E, 8'h01, 8'h00, 8'h00};
    for (int i = 0; i < 7; i++) begin
      if (i > 0) tick;
      bus.ex_mc_start  = (i < 5);
      bus.ex_mc_cycles = 5'd4;
      #1;
      vectors++;
      if ({bus.stall, bus.mc_busy, bus.mc_done} !== exp_v[i]) begin
        miscompares++;
        $display("FAIL mc4_cycle%0d got=%h want=%h", i, {bus.stall, bus.mc_busy, bus.mc_done}, exp_v[i]);
      end
    end
    exp_perf = exp_perf + 4;
    vectors++;
    if (bus.stall_cycles !== exp_perf) begin
      miscompares++;
      $display("FAIL mc4_perf got=%0d want=%0d", bus.stall_cycles, exp_perf);
    end
  endtask

  task automatic test_short;
    logic [7:0] exp_v [3] = '{8'h00, 8'h01, 8'h00};
    logic [4:0] lat   [2] = '{5'd1, 5'd0};
    for (int n = 0; n < 2; n++) begin
      for (int i = 0; i < 3; i++) begin
        tick;
        bus.ex_mc_start  = (i < 2);
        bus.ex_mc_cycles = lat[n];
        #1;
        vectors++;
        if ({bus.stall, bus.mc_busy, bus.mc_done} !== exp_v[i]) begin
          miscompares++;
          $display("FAIL short_lat%0d_cycle%0d got=%h want=%h", lat[n], i,
                   {bus.stall, bus.mc_busy, bus.mc_done}, exp_v[i]);
        end
      end
    end
    vectors++;
    if (bus.stall_cycles !== exp_perf) begin
      miscompares++;
      $display("FAIL short_perf got=%0d want=%0d", bus.stall_cycles, exp_perf);
    end
  endtask

  // Flush on the third BUSY cycle: stall drops at once, no DONE afterwards.
  task automatic test_flush;
    logic [7:0] exp_v [9] = '{8'h3C, 8'h3E, 8'h3E, 8'h02, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
    for (int i = 0; i < 9; i++) begin
      tick;
      bus.ex_mc_start  = (i < 3);
      bus.ex_mc_cycles = 5'd8;
      bus.flush        = (i == 3);
      #1;
      vectors++;
      if ({bus.stall, bus.mc_busy, bus.mc_done} !== exp_v[i]) begin
        miscompares++;
        $display("FAIL flush_cycle%0d got=%h want=%h", i, {bus.stall, bus.mc_busy, bus.mc_done}, exp_v[i]);
      end
    end
    exp_perf = exp_perf + 3;
    vectors++;
    if (bus.stall_cycles !== exp_perf) begin
      miscompares++;
      $display("FAIL flush_perf got=%0d want=%0d", bus.stall_cycles, exp_perf);
    end
  endtask

  // ID request held through a 4-cycle op: EX vector wins while busy.
  task automatic test_back_to_back;
    logic [7:0] exp_v [7] = '{8'h3C, 8'h3E, 8'h3E, 8'h3E, 8'h1D, 8'h1C, 8'h00};
    for (int i = 0; i < 7; i++) begin
      tick;
      bus.stallreq_id  = (i < 6);
      bus.ex_mc_start  = (i < 5);
      bus.ex_mc_cycles = 5'd4;
      #1;
      vectors++;
      if ({bus.stall, bus.mc_busy, bus.mc_done} !== exp_v[i]) begin
        miscompares++;
        $display("FAIL idreq_mc_cycle%0d got=%h want=%h", i, {bus.stall, bus.mc_busy, bus.mc_done}, exp_v[i]);
      end
    end
    exp_perf = exp_perf + 6;
    vectors++;
    if (bus.stall_cycles !== exp_perf) begin
      miscompares++;
      $display("FAIL idreq_mc_perf got=%0d want=%0d", bus.stall_cycles, exp_perf);
    end
  endtask

  task automatic test_saturate;
    logic [2:0] exp_c;
    bus2.stallreq_id = 1'b1;
    for (int k = 0; k < 10; k++) begin
      #1;
      exp_c = (k > 7) ? 3'd7 : 3'(k);
      vectors++;
      if (bus2.stall_cycles !== exp_c) begin
        miscompares++;
        $display("FAIL sat_edge%0d got=%0d want=%0d", k, bus2.stall_cycles, exp_c);
      end
      tick;
    end
    bus2.stallreq_id = 1'b0;
    tick;
    vectors++;
    if (bus2.stall_cycles !== 3'd7) begin
      miscompares++;
      $display("FAIL sat_hold got=%0d want=7", bus2.stall_cycles);
    end
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    exp_perf    = 32'd0;
    test_reset;
    test_stallreq;
    test_mc4;
    test_short;
    test_flush;
    test_back_to_back;
    test_saturate;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
